// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement queue between the dispatcher, the CDB
// and the register file. Entries are allocated at the tail, completed by CDB
// broadcasts in any order, and retired from the head at most one per cycle.
// A mispredicted branch at the head raises a one-cycle flush and empties the
// queue; a retired EXIT stops all further retirement until reset.
module reorder_buffer #(
  parameter int RoB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dispatch_en,
  input  logic [1:0]           dispatch_type,
  input  logic [4:0]           dispatch_rd,
  input  logic                 dispatch_pred,
  input  logic [31:0]          dispatch_alt_pc,
  output logic [RoB_WIDTH-1:0] dispatch_index,
  output logic                 rob_full,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_data,
  input  logic                 cdb_taken,
  input  logic [RoB_WIDTH-1:0] query_j_index,
  input  logic [RoB_WIDTH-1:0] query_k_index,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_data,
  output logic [31:0]          query_k_data,
  output logic                 commit_en,
  output logic [4:0]           commit_reg,
  output logic [RoB_WIDTH-1:0] commit_index,
  output logic [31:0]          commit_data,
  output logic                 store_commit_en,
  output logic                 flush_out,
  output logic [31:0]          flush_pc,
  output logic                 exit_out,
  output logic [31:0]          debug_commit_id
);

  localparam int RoB_SIZE = 1 << RoB_WIDTH;
  localparam int CNT_W    = RoB_WIDTH + 1;

  typedef logic [RoB_WIDTH-1:0] idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  localparam idx_t IDX_ONE  = idx_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(RoB_SIZE);

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_EXIT   = 2'd3
  } rob_type_e;

  // Entry storage
  logic [RoB_SIZE-1:0] busy_q,  busy_d;
  logic [RoB_SIZE-1:0] ready_q, ready_d;
  logic [RoB_SIZE-1:0] pred_q,  pred_d;
  logic [RoB_SIZE-1:0] taken_q, taken_d;
  rob_type_e           type_q   [RoB_SIZE];
  rob_type_e           type_d   [RoB_SIZE];
  logic [4:0]          rd_q     [RoB_SIZE];
  logic [4:0]          rd_d     [RoB_SIZE];
  logic [31:0]         value_q  [RoB_SIZE];
  logic [31:0]         value_d  [RoB_SIZE];
  logic [31:0]         alt_pc_q [RoB_SIZE];
  logic [31:0]         alt_pc_d [RoB_SIZE];

  // Queue pointers
  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t count_q, count_d;

  // Registered outputs
  logic        commit_en_q, commit_en_d;
  logic [4:0]  commit_reg_q, commit_reg_d;
  idx_t        commit_index_q, commit_index_d;
  logic [31:0] commit_data_q, commit_data_d;
  logic        store_commit_q, store_commit_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic        exit_q, exit_d;
  logic [31:0] debug_id_q, debug_id_d;

  // Per-cycle decisions
  logic dispatch_s;
  logic cdb_wr_s;
  logic retire_s;
  logic mispredict_s;

  assign dispatch_index  = tail_q;
  assign rob_full        = (count_q == CNT_FULL);
  assign commit_en       = commit_en_q;
  assign commit_reg      = commit_reg_q;
  assign commit_index    = commit_index_q;
  assign commit_data     = commit_data_q;
  assign store_commit_en = store_commit_q;
  assign flush_out       = flush_q;
  assign flush_pc        = flush_pc_q;
  assign exit_out        = exit_q;
  assign debug_commit_id = debug_id_q;

  // Operand lookup for the j source, with same-cycle CDB bypass
  always_comb begin
    query_j_ready = 1'b0;
    query_j_data  = 32'd0;
    if (flush_q) begin
      query_j_ready = 1'b0;
    end else if (ready_q[query_j_index]) begin
      query_j_ready = 1'b1;
      query_j_data  = value_q[query_j_index];
    end else if (cdb_en && (cdb_index == query_j_index) && busy_q[query_j_index]) begin
      query_j_ready = 1'b1;
      query_j_data  = cdb_data;
    end else begin
      query_j_ready = 1'b0;
    end
  end

  // Operand lookup for the k source, with same-cycle CDB bypass
  always_comb begin
    query_k_ready = 1'b0;
    query_k_data  = 32'd0;
    if (flush_q) begin
      query_k_ready = 1'b0;
    end else if (ready_q[query_k_index]) begin
      query_k_ready = 1'b1;
      query_k_data  = value_q[query_k_index];
    end else if (cdb_en && (cdb_index == query_k_index) && busy_q[query_k_index]) begin
      query_k_ready = 1'b1;
      query_k_data  = cdb_data;
    end else begin
      query_k_ready = 1'b0;
    end
  end

  // Next-state: CDB capture, tail allocation, head retirement and flush
  always_comb begin
    busy_d   = busy_q;
    ready_d  = ready_q;
    pred_d   = pred_q;
    taken_d  = taken_q;
    type_d   = type_q;
    rd_d     = rd_q;
    value_d  = value_q;
    alt_pc_d = alt_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    commit_en_d    = 1'b0;
    store_commit_d = 1'b0;
    flush_d        = 1'b0;
    commit_reg_d   = commit_reg_q;
    commit_index_d = commit_index_q;
    commit_data_d  = commit_data_q;
    flush_pc_d     = flush_pc_q;
    exit_d         = exit_q;
    debug_id_d     = debug_id_q;
    mispredict_s   = 1'b0;

    // Full gating uses the registered count so a same-cycle retire never admits a dispatch
    dispatch_s = rdy_in && dispatch_en && !rob_full && !flush_q;
    cdb_wr_s   = rdy_in && cdb_en && !flush_q && busy_q[cdb_index];
    // Retirement looks only at registered readiness; a CDB write this cycle retires next cycle
    retire_s   = rdy_in && !flush_q && !exit_q && busy_q[head_q] && ready_q[head_q];

    if (cdb_wr_s) begin
      value_d[cdb_index] = cdb_data;
      taken_d[cdb_index] = cdb_taken;
      ready_d[cdb_index] = 1'b1;
    end else begin
      value_d[cdb_index] = value_q[cdb_index];
    end

    if (dispatch_s) begin
      busy_d[tail_q]   = 1'b1;
      ready_d[tail_q]  = (rob_type_e'(dispatch_type) == TYPE_EXIT);
      type_d[tail_q]   = rob_type_e'(dispatch_type);
      rd_d[tail_q]     = dispatch_rd;
      pred_d[tail_q]   = dispatch_pred;
      taken_d[tail_q]  = 1'b0;
      alt_pc_d[tail_q] = dispatch_alt_pc;
      tail_d           = tail_q + IDX_ONE;
    end else begin
      tail_d = tail_q;
    end

    if (retire_s) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_ONE;
      commit_index_d  = head_q;
      debug_id_d      = debug_id_q + 32'd1;
      case (type_q[head_q])
        TYPE_REG: begin
          commit_en_d   = 1'b1;
          commit_reg_d  = rd_q[head_q];
          commit_data_d = value_q[head_q];
        end
        TYPE_STORE: begin
          store_commit_d = 1'b1;
        end
        TYPE_BRANCH: begin
          if (taken_q[head_q] != pred_q[head_q]) begin
            mispredict_s = 1'b1;
            flush_d      = 1'b1;
            flush_pc_d   = alt_pc_q[head_q];
          end else begin
            mispredict_s = 1'b0;
          end
        end
        TYPE_EXIT: begin
          exit_d = 1'b1;
        end
        default: begin
          commit_en_d = 1'b0;
        end
      endcase
    end else begin
      head_d = head_q;
    end

    if (dispatch_s && !retire_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!dispatch_s && retire_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end

    // A mispredict discards every younger entry, including any dispatched this cycle
    if (mispredict_s) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and registered-output update
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      pred_q         <= '0;
      taken_q        <= '0;
      for (int i = 0; i < RoB_SIZE; i++) begin
        type_q[i]   <= TYPE_REG;
        rd_q[i]     <= 5'd0;
        value_q[i]  <= 32'd0;
        alt_pc_q[i] <= 32'd0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_reg_q   <= 5'd0;
      commit_index_q <= '0;
      commit_data_q  <= 32'd0;
      store_commit_q <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= 32'd0;
      exit_q         <= 1'b0;
      debug_id_q     <= 32'd0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      pred_q         <= pred_d;
      taken_q        <= taken_d;
      type_q         <= type_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      alt_pc_q       <= alt_pc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_en_q    <= commit_en_d;
      commit_reg_q   <= commit_reg_d;
      commit_index_q <= commit_index_d;
      commit_data_q  <= commit_data_d;
      store_commit_q <= store_commit_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
      exit_q         <= exit_d;
      debug_id_q     <= debug_id_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. Expected retirements are queued
// in program order as instructions are dispatched and compared whenever the
// DUT raises a commit, store-commit or flush strobe.
module tb_reorder_buffer;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        dispatch_en;
  logic [1:0]  dispatch_type;
  logic [4:0]  dispatch_rd;
  logic        dispatch_pred;
  logic [31:0] dispatch_alt_pc;
  logic [2:0]  dispatch_index;
  logic        rob_full;
  logic        cdb_en;
  logic [2:0]  cdb_index;
  logic [31:0] cdb_data;
  logic        cdb_taken;
  logic [2:0]  query_j_index;
  logic [2:0]  query_k_index;
  logic        query_j_ready;
  logic        query_k_ready;
  logic [31:0] query_j_data;
  logic [31:0] query_k_data;
  logic        commit_en;
  logic [4:0]  commit_reg;
  logic [2:0]  commit_index;
  logic [31:0] commit_data;
  logic        store_commit_en;
  logic        flush_out;
  logic [31:0] flush_pc;
  logic        exit_out;
  logic [31:0] debug_commit_id;

  reorder_buffer #(.RoB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dispatch_en(dispatch_en), .dispatch_type(dispatch_type), .dispatch_rd(dispatch_rd),
    .dispatch_pred(dispatch_pred), .dispatch_alt_pc(dispatch_alt_pc),
    .dispatch_index(dispatch_index), .rob_full(rob_full),
    .cdb_en(cdb_en), .cdb_index(cdb_index), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
    .query_j_index(query_j_index), .query_k_index(query_k_index),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_data(query_j_data), .query_k_data(query_k_data),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_index(commit_index),
    .commit_data(commit_data), .store_commit_en(store_commit_en),
    .flush_out(flush_out), .flush_pc(flush_pc), .exit_out(exit_out),
    .debug_commit_id(debug_commit_id)
  );

  // strobes = {flush, store, commit}; data is commit value or flush PC
  typedef struct packed {
    logic [2:0]  strobes;
    logic [4:0]  rd;
    logic [2:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_tail = 3'd0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_dispatch(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                             input logic [31:0] alt, input bit push, input logic [2:0] strobes,
                             input logic [31:0] d);
    exp_t e;
    check_eq("dispatch_index", 32'(dispatch_index), 32'(exp_tail));
    dispatch_en     = 1'b1;
    dispatch_type   = t;
    dispatch_rd     = rd;
    dispatch_pred   = pred;
    dispatch_alt_pc = alt;
    if (push) begin
      e.strobes = strobes;
      e.rd      = rd;
      e.idx     = exp_tail;
      e.data    = d;
      sb.push_back(e);
    end
    step();
    dispatch_en = 1'b0;
    exp_tail    = exp_tail + 3'd1;
  endtask

  task automatic do_cdb(input logic [2:0] idx, input logic [31:0] d, input logic tk);
    cdb_en    = 1'b1;
    cdb_index = idx;
    cdb_data  = d;
    cdb_taken = tk;
    step();
    cdb_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    check_eq("drain_remaining", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected retirement
  always @(negedge clk_in) begin
    if (!rst_in && (commit_en || store_commit_en || flush_out)) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_strobe", {29'd0, flush_out, store_commit_en, commit_en}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_strobes", {29'd0, flush_out, store_commit_en, commit_en}, 32'(mon_e.strobes));
        if (mon_e.strobes[0]) begin
          check_eq("sb_commit_reg", 32'(commit_reg), 32'(mon_e.rd));
          check_eq("sb_commit_index", 32'(commit_index), 32'(mon_e.idx));
          check_eq("sb_commit_data", commit_data, mon_e.data);
        end else if (mon_e.strobes[1]) begin
          check_eq("sb_store_index", 32'(commit_index), 32'(mon_e.idx));
        end else begin
          check_eq("sb_flush_pc", flush_pc, mon_e.data);
        end
      end
    end
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    dispatch_en = 1'b0; dispatch_type = 2'd0; dispatch_rd = 5'd0;
    dispatch_pred = 1'b0; dispatch_alt_pc = 32'd0;
    cdb_en = 1'b0; cdb_index = 3'd0; cdb_data = 32'd0; cdb_taken = 1'b0;
    query_j_index = 3'd0; query_k_index = 3'd0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Reset state
    check_eq("rst_rob_full", 32'(rob_full), 32'd0);
    check_eq("rst_dispatch_index", 32'(dispatch_index), 32'd0);
    check_eq("rst_commit_en", 32'(commit_en), 32'd0);
    check_eq("rst_debug_id", debug_commit_id, 32'd0);

    // Fill the buffer with 8 REG entries, then try a 9th
    for (int i = 0; i < 8; i++)
      do_dispatch(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b1, 3'b001, 32'h11 * 32'(i + 1));
    check_eq("full_after_8", 32'(rob_full), 32'd1);
    dispatch_en = 1'b1; dispatch_type = 2'd0; dispatch_rd = 5'd20;
    step();
    dispatch_en = 1'b0;
    check_eq("full_tail_held", 32'(dispatch_index), 32'd0);
    check_eq("full_still", 32'(rob_full), 32'd1);
    do_cdb(3'd0, 32'h11, 1'b0);
    step();
    check_eq("first_commit_en", 32'(commit_en), 32'd1);
    check_eq("first_commit_reg", 32'(commit_reg), 32'd1);
    check_eq("first_commit_data", commit_data, 32'h11);
    check_eq("first_debug_id", debug_commit_id, 32'd1);

    // Out-of-order completion, in-order retirement on consecutive cycles
    do_cdb(3'd3, 32'h44, 1'b0);
    do_cdb(3'd2, 32'h33, 1'b0);
    do_cdb(3'd1, 32'h22, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("ooo_commit_en", 32'(commit_en), 32'd1);
      check_eq("ooo_commit_index", 32'(commit_index), 32'(i));
    end
    // Head wraps 7 -> 0
    do_dispatch(2'd0, 5'd9, 1'b0, 32'd0, 1'b1, 3'b001, 32'h99);
    for (int i = 4; i < 8; i++) do_cdb(3'(i), 32'h11 * 32'(i + 1), 1'b0);
    do_cdb(3'd0, 32'h99, 1'b0);
    drain(20);
    check_eq("wrap_debug_id", debug_commit_id, 32'd9);

    // Mispredicted branch with two completed younger entries
    do_dispatch(2'd2, 5'd0, 1'b0, 32'h1000, 1'b1, 3'b100, 32'h1000);
    do_dispatch(2'd0, 5'd10, 1'b0, 32'd0, 1'b0, 3'b001, 32'hAA);
    do_dispatch(2'd0, 5'd11, 1'b0, 32'd0, 1'b0, 3'b001, 32'hBB);
    do_cdb(3'd2, 32'hAA, 1'b0);
    do_cdb(3'd3, 32'hBB, 1'b0);
    do_cdb(3'd1, 32'd0, 1'b1);
    step();
    query_j_index = 3'd2;
    #1;
    check_eq("flush_out", 32'(flush_out), 32'd1);
    check_eq("flush_pc", flush_pc, 32'h1000);
    check_eq("flush_query_ready", 32'(query_j_ready), 32'd0);
    dispatch_en = 1'b1; dispatch_type = 2'd0; dispatch_rd = 5'd21;
    step();
    dispatch_en = 1'b0;
    exp_tail = 3'd0;
    check_eq("flush_one_cycle", 32'(flush_out), 32'd0);
    check_eq("flush_tail_zero", 32'(dispatch_index), 32'd0);
    check_eq("flush_not_full", 32'(rob_full), 32'd0);
    check_eq("flush_debug_id", debug_commit_id, 32'd10);
    repeat (4) step();
    check_eq("flush_no_pending", 32'(sb.size()), 32'd0);

    // Query bypass and store commit
    do_dispatch(2'd0, 5'd5, 1'b0, 32'd0, 1'b1, 3'b001, 32'h50);
    do_dispatch(2'd1, 5'd0, 1'b0, 32'd0, 1'b1, 3'b010, 32'd0);
    do_dispatch(2'd0, 5'd6, 1'b0, 32'd0, 1'b1, 3'b001, 32'h60);
    do_dispatch(2'd0, 5'd7, 1'b0, 32'd0, 1'b1, 3'b001, 32'hABCD);
    query_j_index = 3'd3; query_k_index = 3'd5;
    cdb_en = 1'b1; cdb_index = 3'd3; cdb_data = 32'hABCD; cdb_taken = 1'b0;
    #1;
    check_eq("bypass_ready", 32'(query_j_ready), 32'd1);
    check_eq("bypass_data", query_j_data, 32'hABCD);
    check_eq("nonbusy_ready", 32'(query_k_ready), 32'd0);
    check_eq("nonbusy_data", query_k_data, 32'd0);
    step();
    cdb_en = 1'b0;
    check_eq("stored_ready", 32'(query_j_ready), 32'd1);

    // Pause with a ready head
    do_cdb(3'd0, 32'h50, 1'b0);
    rdy_in = 1'b0;
    dispatch_en = 1'b1; dispatch_type = 2'd0; dispatch_rd = 5'd22;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("pause_commit_en", 32'(commit_en), 32'd0);
      check_eq("pause_tail", 32'(dispatch_index), 32'd4);
    end
    rdy_in = 1'b1;
    dispatch_en = 1'b0;
    step();
    check_eq("resume_commit_en", 32'(commit_en), 32'd1);
    check_eq("resume_commit_index", 32'(commit_index), 32'd0);
    do_cdb(3'd1, 32'h1234, 1'b0);
    do_cdb(3'd2, 32'h60, 1'b0);
    drain(20);
    check_eq("pause_debug_id", debug_commit_id, 32'd14);

    // Asynchronous reset with five live entries
    for (int i = 0; i < 5; i++) do_dispatch(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 3'b001, 32'd0);
    do_cdb(3'd4, 32'h77, 1'b0);
    #2 rst_in = 1'b1;
    #1;
    check_eq("async_rst_full", 32'(rob_full), 32'd0);
    check_eq("async_rst_tail", 32'(dispatch_index), 32'd0);
    check_eq("async_rst_debug", debug_commit_id, 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    exp_tail = 3'd0;
    step();
    check_eq("rst_strobes", {29'd0, flush_out, store_commit_en, commit_en}, 32'd0);
    check_eq("rst_tail_after", 32'(dispatch_index), 32'd0);

    // EXIT retires immediately and blocks all later retirement
    do_dispatch(2'd3, 5'd0, 1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
    do_dispatch(2'd0, 5'd12, 1'b0, 32'd0, 1'b0, 3'b001, 32'hEE);
    check_eq("exit_out", 32'(exit_out), 32'd1);
    do_cdb(3'd1, 32'hEE, 1'b0);
    repeat (3) step();
    check_eq("exit_sticky", 32'(exit_out), 32'd1);
    check_eq("exit_no_commit", 32'(commit_en), 32'd0);
    check_eq("exit_debug_id", debug_commit_id, 32'd1);
    check_eq("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
